// File: rtl/two_bit_comparator_unit_pkg.sv
// Shared compare-result encoding for the magnitude comparator and its 2-bit slices.
// The one-hot result is ordered {GT, LT, EQ} so it unpacks directly onto the output flags.
package two_bit_comparator_unit_pkg;

  typedef enum logic [2:0] {
    CMP_NONE = 3'b000,
    CMP_EQ   = 3'b001,
    CMP_LT   = 3'b010,
    CMP_GT   = 3'b100
  } cmp_res_t;

  // An unequal slice is either greater or less, so its gt bit alone selects the result.
  function automatic cmp_res_t cmp_pick(input logic gt);
    return gt ? CMP_GT : CMP_LT;
  endfunction

endpackage

// File: rtl/two_bit_comparator_unit_cmp2_slice.sv
// Purely combinational unsigned compare of one 2-bit slice.
module cmp2_slice (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic       o_gt,
  output logic       o_lt,
  output logic       o_eq
);

  logic w_msb_eq;

  assign w_msb_eq = ~(i_a[1] ^ i_b[1]);
  assign o_gt     = (i_a[1] & ~i_b[1]) | (w_msb_eq & i_a[0] & ~i_b[0]);
  assign o_lt     = (~i_a[1] & i_b[1]) | (w_msb_eq & ~i_a[0] & i_b[0]);
  assign o_eq     = w_msb_eq & ~(i_a[0] ^ i_b[0]);

endmodule

// File: rtl/two_bit_comparator_unit.sv
// Registered unsigned magnitude comparator built from cascaded 2-bit slices;
// one-hot gt/lt/eq flags appear one clock after a valid operand pair.
module two_bit_comparator_unit
  import two_bit_comparator_unit_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             out_valid
);

  localparam int NSL = (WIDTH < 2) ? 1 : WIDTH / 2;

  if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_bad_width
    $error("two_bit_comparator_unit: WIDTH must be even and >= 2");
  end

  logic [NSL-1:0] w_gt_p0;
  logic [NSL-1:0] w_lt_p0;
  logic [NSL-1:0] w_eq_p0;
  cmp_res_t       w_res_p0;
  cmp_res_t       r_res_p1;
  logic           r_vld_p1;

  // Stage p0: per-slice compare and MSB-first cascade
  for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
    cmp2_slice u_slice (
      .i_a  (a[2*gi +: 2]),
      .i_b  (b[2*gi +: 2]),
      .o_gt (w_gt_p0[gi]),
      .o_lt (w_lt_p0[gi]),
      .o_eq (w_eq_p0[gi])
    );
  end

  // Walking LSB to MSB lets the most significant unequal slice overwrite lower ones.
  always_comb begin
    w_res_p0 = CMP_EQ;
    for (int i = 0; i < NSL; i++) begin
      if (!w_eq_p0[i]) begin
        w_res_p0 = cmp_pick(w_gt_p0[i]);
      end
    end
  end

  // Stage p1: output register; flags hold when no new operands arrive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_p1 <= CMP_NONE;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_res_p1 <= w_res_p0;
      end
    end
  end

  assign a_gt_b    = r_res_p1[2];
  assign a_lt_b    = r_res_p1[1];
  assign a_eq_b    = r_res_p1[0];
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_two_bit_comparator_unit.sv
// Randomised and directed bench for the registered comparator at WIDTH=2 and WIDTH=8.
module tb_two_bit_comparator_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld2, vld8;
  logic [1:0] a2, b2;
  logic [7:0] a8, b8;
  logic       gt2, lt2, eq2, ov2;
  logic       gt8, lt8, eq8, ov8;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {gt, lt, eq, valid} for each instance
  logic [3:0] exp2, exp8;

  always #5 clk = ~clk;

  two_bit_comparator_unit #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld2), .a(a2), .b(b2),
    .a_gt_b(gt2), .a_lt_b(lt2), .a_eq_b(eq2), .out_valid(ov2)
  );

  two_bit_comparator_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld8), .a(a8), .b(b8),
    .a_gt_b(gt8), .a_lt_b(lt8), .a_eq_b(eq8), .out_valid(ov8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_w2"}, {28'd0, gt2, lt2, eq2, ov2}, {28'd0, exp2});
    chk({tag, "_w8"}, {28'd0, gt8, lt8, eq8, ov8}, {28'd0, exp8});
    if (exp2[0]) chk({tag, "_w2_onehot"}, $countones({gt2, lt2, eq2}), 1);
    if (exp8[0]) chk({tag, "_w8_onehot"}, $countones({gt8, lt8, eq8}), 1);
  endtask

  // Reference: plain unsigned relational operators, held when no valid input
  function automatic logic [3:0] ref_next(input logic [3:0] prev, input logic v,
                                          input int unsigned x, input int unsigned y);
    logic [3:0] r;
    r = prev;
    if (v) begin
      r[3] = (x > y);
      r[2] = (x < y);
      r[1] = (x == y);
    end
    r[0] = v;
    return r;
  endfunction

  task automatic cycle(input string tag);
    @(posedge clk);
    exp2 = ref_next(exp2, vld2, a2, b2);
    exp8 = ref_next(exp8, vld8, a8, b8);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [1:0] x2, input logic [1:0] y2, input logic v2,
                       input logic [7:0] x8, input logic [7:0] y8, input logic v8);
    a2 = x2; b2 = y2; vld2 = v2;
    a8 = x8; b8 = y8; vld8 = v8;
  endtask

  initial begin
    exp2 = 4'b0;
    exp8 = 4'b0;
    rst_n = 1'b0;
    drive(2'b10, 2'b01, 1'b1, 8'd2, 8'd1, 1'b1);
    #2;
    check_all("reset_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all("reset_held");
    end
    @(negedge clk);
    rst_n = 1'b1;

    drive(2'b10, 2'b01, 1'b1, 8'd200, 8'd13, 1'b1);   cycle("gt_a");
    drive(2'b11, 2'b10, 1'b1, 8'd255, 8'd254, 1'b1);  cycle("gt_b");
    drive(2'b01, 2'b10, 1'b1, 8'd0, 8'd1, 1'b1);      cycle("lt_a");
    drive(2'b01, 2'b11, 1'b1, 8'h7f, 8'h80, 1'b1);    cycle("lt_b");
    for (int i = 3; i >= 0; i--) begin
      drive(i[1:0], i[1:0], 1'b1, 8'(i * 85), 8'(i * 85), 1'b1);
      cycle("eq");
    end

    drive(2'b11, 2'b10, 1'b1, 8'h81, 8'h80, 1'b1);    cycle("hold_cap");
    drive(2'b00, 2'b11, 1'b0, 8'h00, 8'hff, 1'b0);    cycle("hold_1");
    cycle("hold_2");

    for (int i = 0; i < 16; i++) begin
      drive(i[3:2], i[1:0], 1'b1, 8'($urandom), 8'($urandom), 1'b1);
      cycle("exh");
    end

    for (int i = 0; i < 200; i++) begin
      logic [7:0] x;
      x = 8'($urandom);
      drive(2'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0),
            x, ($urandom_range(0, 3) == 0) ? x : 8'($urandom),
            1'($urandom_range(0, 3) != 0));
      cycle("rand");
    end

    drive(2'b11, 2'b00, 1'b1, 8'd9, 8'd9, 1'b1);      cycle("pre_rst");
    drive(2'b00, 2'b11, 1'b1, 8'd1, 8'd2, 1'b1);
    #2;
    rst_n = 1'b0;
    exp2 = 4'b0;
    exp8 = 4'b0;
    #1;
    check_all("midrst_async");
    @(posedge clk);
    #1;
    check_all("midrst_held");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
